// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, sync polarity and TinyVGA PMOD packing.
// Imported by the timing generator and by the pattern tops downstream.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT
                                 + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT
                                 + VGA_V_SYNC + VGA_V_BACK;

    localparam logic VGA_SYNC_ACT = 1'b0;

    localparam int POS_W   = 10;
    localparam int POS_MAX = 1 << POS_W;

    // TinyVGA PMOD pin order, MSB first: {hsync,B0,G0,R0,vsync,B1,G1,R1}
    typedef struct packed {
        logic hsync;
        logic b0;
        logic g0;
        logic r0;
        logic vsync;
        logic b1;
        logic g1;
        logic r1;
    } pmod_t;

    localparam int PMOD_R1    = 0;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_HSYNC = 7;

    function automatic pmod_t pmod_pack(
        input logic       hs,
        input logic       vs,
        input logic [1:0] r,
        input logic [1:0] g,
        input logic [1:0] b
    );
        pmod_t p;
        p.hsync = hs;
        p.b0    = b[0];
        p.g0    = g[0];
        p.r0    = r[0];
        p.vsync = vs;
        p.b1    = b[1];
        p.g1    = g[1];
        p.r1    = r[1];
        return p;
    endfunction

    function automatic logic in_window(
        input logic [POS_W-1:0] pos,
        input int               lo,
        input int               hi
    );
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MAX counter with enable, exposing both current and next count.
// wrap_o is combinational: high on the enabled step that returns to zero.
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX   = VGA_H_TOTAL,
    parameter int WIDTH = POS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_d_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == LAST);
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/vga_sync_timing.sv
// Raster timing stage: chained h/v counters plus registered sync, blanking
// and line/frame strobes decoded from next-state counters (zero skew).
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY = VGA_H_DISPLAY,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_DISPLAY = VGA_V_DISPLAY,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_ACT  = VGA_SYNC_ACT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int HS_LO = H_DISPLAY + H_FRONT;
    localparam int HS_HI = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int VS_LO = V_DISPLAY + V_FRONT;
    localparam int VS_HI = V_DISPLAY + V_FRONT + V_SYNC;

    if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_size_check
        $error("vga_sync_timing: H_TOTAL/V_TOTAL exceed counter range");
    end

    logic [POS_W-1:0] h_count;
    logic [POS_W-1:0] h_next;
    logic             h_wrap;
    logic [POS_W-1:0] v_count;
    logic [POS_W-1:0] v_next;
    logic             v_wrap;

    vga_wrap_counter #(
        .MAX   (H_TOTAL),
        .WIDTH (POS_W)
    ) u_hcnt (
        .clk       (clk),
        .reset     (reset),
        .en_i      (tick_en),
        .count_o   (h_count),
        .count_d_o (h_next),
        .wrap_o    (h_wrap)
    );

    vga_wrap_counter #(
        .MAX   (V_TOTAL),
        .WIDTH (POS_W)
    ) u_vcnt (
        .clk       (clk),
        .reset     (reset),
        .en_i      (h_wrap),
        .count_o   (v_count),
        .count_d_o (v_next),
        .wrap_o    (v_wrap)
    );

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    // Strobes are single-tick: they drop whenever tick_en is low.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        fc_d    = fc_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (tick_en) begin
            hsync_d = in_window(h_next, HS_LO, HS_HI) ? SYNC_ACT : ~SYNC_ACT;
            vsync_d = in_window(v_next, VS_LO, VS_HI) ? SYNC_ACT : ~SYNC_ACT;
            de_d    = (int'(h_next) < H_DISPLAY) && (int'(v_next) < V_DISPLAY);
            ls_d    = h_wrap;
            fs_d    = v_wrap;
            if (v_wrap) begin
                fc_d = fc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 8'd0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = de_q;
    assign hpos        = h_count;
    assign vpos        = v_count;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: full-size instance for line timing, a shrunken
// instance for frame, vsync-run and frame_count wrap behaviour.
module tb_vga_sync_timing;

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb;
    } prm_t;

    typedef struct {
        int   h, v, fc;
        logic hs, vs, de, ls, fs;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;

    logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [9:0] hpos_a, vpos_a;
    logic [7:0] fc_a;

    logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [9:0] hpos_b, vpos_b;
    logic [7:0] fc_b;

    always #5 clk = ~clk;

    vga_sync_timing dut_a (
        .clk         (clk),
        .reset       (reset),
        .tick_en     (tick_en),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .display_on  (de_a),
        .hpos        (hpos_a),
        .vpos        (vpos_a),
        .line_start  (ls_a),
        .frame_start (fs_a),
        .frame_count (fc_a)
    );

    vga_sync_timing #(
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_DISPLAY (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (2)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .tick_en     (tick_en),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .display_on  (de_b),
        .hpos        (hpos_b),
        .vpos        (vpos_b),
        .line_start  (ls_b),
        .frame_start (fs_b),
        .frame_count (fc_b)
    );

    int    passed = 0;
    int    fails  = 0;
    int    total  = 0;
    prm_t  pa, pb;
    st_t   ma, mb;
    pair_t sb[$];

    function automatic st_t rst_st();
        st_t s;
        s.h  = 0;
        s.v  = 0;
        s.fc = 0;
        s.hs = 1'b1;
        s.vs = 1'b1;
        s.de = 1'b0;
        s.ls = 1'b0;
        s.fs = 1'b0;
        return s;
    endfunction

    function automatic st_t nxt(input st_t s, input prm_t p, input logic te);
        st_t n;
        int  ht;
        int  vt;
        ht   = p.hd + p.hf + p.hs + p.hb;
        vt   = p.vd + p.vf + p.vs + p.vb;
        n    = s;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (te) begin
            n.h = s.h + 1;
            if (n.h == ht) begin
                n.h  = 0;
                n.ls = 1'b1;
                n.v  = s.v + 1;
                if (n.v == vt) begin
                    n.v  = 0;
                    n.fs = 1'b1;
                    n.fc = (s.fc + 1) % 256;
                end
            end
            n.hs = !(n.h >= p.hd + p.hf && n.h < p.hd + p.hf + p.hs);
            n.vs = !(n.v >= p.vd + p.vf && n.v < p.vd + p.vf + p.vs);
            n.de = (n.h < p.hd) && (n.v < p.vd);
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string who, input st_t e,
                       input logic [9:0] h, input logic [9:0] v,
                       input logic [7:0] fc, input logic hs, input logic vs,
                       input logic de, input logic ls, input logic fs);
        chk({who, ".hpos"}, 32'(h), 32'(e.h));
        chk({who, ".vpos"}, 32'(v), 32'(e.v));
        chk({who, ".frame_count"}, 32'(fc), 32'(e.fc));
        chk({who, ".hsync"}, 32'(hs), 32'(e.hs));
        chk({who, ".vsync"}, 32'(vs), 32'(e.vs));
        chk({who, ".display_on"}, 32'(de), 32'(e.de));
        chk({who, ".line_start"}, 32'(ls), 32'(e.ls));
        chk({who, ".frame_start"}, 32'(fs), 32'(e.fs));
    endtask

    task automatic cmp_both(input pair_t p);
        cmp("a", p.a, hpos_a, vpos_a, fc_a, hsync_a, vsync_a, de_a, ls_a, fs_a);
        cmp("b", p.b, hpos_b, vpos_b, fc_b, hsync_b, vsync_b, de_b, ls_b, fs_b);
    endtask

    task automatic step(input logic te);
        pair_t p;
        tick_en = te;
        ma  = nxt(ma, pa, te);
        mb  = nxt(mb, pb, te);
        p.a = ma;
        p.b = mb;
        sb.push_back(p);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        cmp_both(p);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pair_t p;
        int    hs_low, hs_first, hs_last, de_cnt, de640, ls_cnt, fs_cnt;
        int    fs_b_cnt, wrap_seen, run, last_run;

        pa = '{640, 16, 96, 48, 480, 10, 2, 33};
        pb = '{8, 2, 3, 3, 6, 2, 2, 2};

        reset   = 1'b1;
        tick_en = 1'b0;
        ma      = rst_st();
        mb      = rst_st();
        @(posedge clk);
        #1;
        p.a = ma;
        p.b = mb;
        sb.push_back(p);
        cmp_both(sb.pop_front());
        reset = 1'b0;

        step(1'b0);

        hs_low   = 0;
        hs_first = -1;
        hs_last  = -1;
        de_cnt   = 0;
        de640    = -1;
        ls_cnt   = 0;
        fs_cnt   = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (vpos_a == 10'd0) begin
                if (hsync_a == 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(hpos_a);
                    hs_last = int'(hpos_a);
                end
                if (de_a) de_cnt++;
                if (hpos_a == 10'd640) de640 = int'(de_a);
            end
            ls_cnt += int'(ls_a);
            fs_cnt += int'(fs_a);
        end
        chk("line0.hpos_wrap", 32'(hpos_a), 32'd0);
        chk("line0.vpos", 32'(vpos_a), 32'd1);
        chk("line0.hsync_low_clks", 32'(hs_low), 32'd96);
        chk("line0.hsync_first", 32'(hs_first), 32'd656);
        chk("line0.hsync_last", 32'(hs_last), 32'd751);
        chk("line0.display_clks", 32'(de_cnt), 32'd639);
        chk("line0.display_at_640", 32'(de640), 32'd0);
        chk("line0.line_start_cnt", 32'(ls_cnt), 32'd1);
        chk("line0.frame_start_cnt", 32'(fs_cnt), 32'd0);

        for (int i = 0; i < 799; i++) step(1'b1);
        ls_cnt = 0;
        step(1'b1);
        ls_cnt += int'(ls_a);
        step(1'b0);
        ls_cnt += int'(ls_a);
        step(1'b0);
        ls_cnt += int'(ls_a);
        step(1'b1);
        ls_cnt += int'(ls_a);
        chk("gate.hpos", 32'(hpos_a), 32'd1);
        chk("gate.line_start_cnt", 32'(ls_cnt), 32'd1);

        fs_b_cnt  = 0;
        wrap_seen = 0;
        run       = 0;
        last_run  = 0;
        for (int i = 0; i < 256 * 192; i++) begin
            step(1'b1);
            if (fs_b) begin
                fs_b_cnt++;
                if (fc_b == 8'd0) wrap_seen++;
            end
            if (!vsync_b) begin
                run++;
            end else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
        end
        chk("frames.frame_start_cnt", 32'(fs_b_cnt), 32'd256);
        chk("frames.fc_wrap_at_start", 32'(wrap_seen), 32'd1);
        chk("frames.vsync_run", 32'(last_run), 32'd32);

        for (int i = 0; i < 800 && ma.h != 300; i++) step(1'b1);
        chk("midreset.hpos_before", 32'(hpos_a), 32'd300);
        #2;
        reset = 1'b1;
        #1;
        ma  = rst_st();
        mb  = rst_st();
        p.a = ma;
        p.b = mb;
        sb.push_back(p);
        cmp_both(sb.pop_front());
        @(negedge clk);
        reset = 1'b0;
        step(1'b1);
        chk("restart.hpos", 32'(hpos_a), 32'd1);
        chk("restart.vpos", 32'(vpos_a), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
